ifu_inst_queue: RTL and testbench
=================================

# ifu_inst_queue

Instruction queue sitting directly downstream of the AXI instruction-fetch unit and upstream of the decode stage. It accepts fetched {pc, inst} pairs through a valid/ready handshake, buffers up to DEPTH of them in a circular FIFO, and presents them in order to decode. A flush input discards all buffered entries on a control-flow redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 64, PC width
- INST_W, 32, instruction width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- io_in_valid  in  1  fetch stage offers an instruction
- io_in_ready  out  1  queue accepts this cycle
- io_in_pc  in  PC_W  PC of offered instruction
- io_in_inst  in  INST_W  offered instruction word
- io_out_valid  out  1  head entry available to decode
- io_out_ready  in  1  decode consumes head this cycle
- io_out_pc  out  PC_W  head PC
- io_out_inst  out  INST_W  head instruction
- io_flush  in  1  discard all entries (redirect)
- io_count  out  log2(DEPTH)+1  current occupancy

## Operation
- State: storage array of DEPTH×(PC_W+INST_W); wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Enqueue fires when io_in_valid & io_in_ready: write at wr_ptr, wr_ptr+1.
- Dequeue fires when io_out_valid & io_out_ready: rd_ptr+1.
- count += enq − deq; simultaneous enq and deq leaves count unchanged.
- io_in_ready = (count != DEPTH) & ~io_flush; it does not depend on io_out_ready, so no enqueue occurs while full even if a dequeue fires in the same cycle.
- io_out_valid = (count != 0) & ~io_flush (see Configuration for bypass).
- io_out_pc and io_out_inst are driven to 0 whenever io_out_valid is 0; otherwise they carry the entry at rd_ptr.
- Flush: when io_flush is 1, no enqueue or dequeue fires. On the next edge, wr_ptr, rd_ptr and count go to 0. Flush has priority over all other events.
- Storage contents are not reset; only pointers and count are reset.
- io_count = count.

## Timing
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. While reset is asserted: io_in_ready=0, io_out_valid=0, io_out_pc=0, io_out_inst=0, io_count=0.
- First cycle after reset release: io_in_ready=1, io_out_valid=0.
- Latency with bypass disabled: an entry enqueued at edge N is visible on io_out at cycle N+1 (1 cycle).
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- Full: count=DEPTH gives io_in_ready=0. It returns to 1 the cycle after the first dequeue.
- Empty: count=0 gives io_out_valid=0 (unless bypass applies).
- Pointer wrap: pointer DEPTH−1 followed by 0; order must be preserved across wrap.
- Reset asserted mid-transfer aborts any handshake immediately; no partial state survives.

## Configuration
- Macro IFU_IQ_BYPASS_EN.
- Defined:
  - When count=0 and io_flush=0, io_out_valid = io_in_valid, and io_out_pc/io_out_inst = io_in_pc/io_in_inst combinationally.
  - If io_out_ready is also 1, the entry passes through with no write and no pointer or count change (0-cycle latency).
  - If io_out_ready is 0, the entry is written normally.
- Undefined: no combinational path from io_in_* to io_out_*; minimum latency is 1 cycle as above.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release → io_in_ready=1, io_out_valid=0, io_count=0, io_out_pc=0.
- Ordered fill/drain: enqueue pc 0x80000000/0x80000004/0x80000008/0x8000000C with io_out_ready=0 → io_count=4, io_in_ready=0; then io_out_ready=1 → four outputs in the same order, then io_out_valid=0.
- Streaming with wrap: 10 back-to-back enqueues with io_out_ready=1 → one output per cycle, no loss or reorder, io_count stays ≤1 (0 with IFU_IQ_BYPASS_EN).
- Full plus simultaneous dequeue: at count=4, io_in_valid=1 and io_out_ready=1 → dequeue only, count=3; enqueue accepted the next cycle.
- Flush: with count=3, pulse io_flush for 1 cycle while io_in_valid=1 → io_in_ready=0 and io_out_valid=0 that cycle; next cycle io_count=0 and the offered entry is dropped.
- Bypass: with IFU_IQ_BYPASS_EN, queue empty, io_in_valid=1 with inst 0x00000013, io_out_ready=1 → io_out_valid=1 with io_out_inst=0x00000013 in the same cycle, io_count stays 0; without the macro, output appears 1 cycle later.

Source files
------------

// File: rtl/ifu_inst_queue.sv
// Circular instruction queue between the AXI fetch unit and decode; flush empties it on redirect.
// Optional zero-latency empty-queue bypass is enabled by defining IFU_IQ_BYPASS_EN.
module ifu_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [PC_W-1:0]            io_in_pc,
  input  logic [INST_W-1:0]          io_in_inst,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [PC_W-1:0]            io_out_pc,
  output logic [INST_W-1:0]          io_out_inst,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic   empty;
  logic   out_valid;
  logic   pass_through;
  logic   enq;
  logic   deq;
  entry_t head;

  assign empty = (count == '0);

  // Reset gates ready so nothing is offered as accepted while the queue is held in reset.
  assign io_in_ready = reset & (count != FULL) & ~io_flush;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    out_valid    = reset & ~empty & ~io_flush;
    head         = mem[rd_ptr];
    pass_through = 1'b0;
`ifdef IFU_IQ_BYPASS_EN
    if (reset && empty && !io_flush) begin
      out_valid    = io_in_valid;
      head         = '{pc: io_in_pc, inst: io_in_inst};
      pass_through = io_in_valid & io_out_ready;
    end
`endif
  end

  // A bypassed entry is neither written nor counted as a dequeue of stored data.
  assign enq = io_in_valid & io_in_ready & ~pass_through;
  assign deq = out_valid & io_out_ready & ~pass_through;

  assign io_out_valid = out_valid;
  assign io_out_pc    = out_valid ? head.pc   : '0;
  assign io_out_inst  = out_valid ? head.inst : '0;
  assign io_count     = count;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= '{pc: io_in_pc, inst: io_in_inst};
  end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed self-checking bench for ifu_inst_queue; expectations follow IFU_IQ_BYPASS_EN when defined.
module tb_ifu_inst_queue;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_in_pc;
  logic [31:0] io_in_inst;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_pc;
  logic [31:0] io_out_inst;
  logic        io_flush;
  logic [2:0]  io_count;

  int errors = 0;
  int checks = 0;

  ifu_inst_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_pc     (io_in_pc),
    .io_in_inst   (io_in_inst),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_pc    (io_out_pc),
    .io_out_inst  (io_out_inst),
    .io_flush     (io_flush),
    .io_count     (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    io_in_valid  = v;
    io_in_pc     = pc;
    io_in_inst   = inst;
    io_out_ready = rdy;
    io_flush     = fl;
  endtask

  // Leaves the bench 1 time unit after a rising edge, with registered state settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Reset held for three cycles, then released
    repeat (3) tick();
    #1;
    check("rst_in_ready", io_in_ready, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_count", io_count, 0);
    check("rst_out_pc", io_out_pc, 0);
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("idle_in_ready", io_in_ready, 1);
    check("idle_out_valid", io_out_valid, 0);
    check("idle_count", io_count, 0);
    check("idle_out_pc", io_out_pc, 0);
    tick();

    // Ordered fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      #1;
      check("fill_ready", io_in_ready, 1);
      tick();
      check("fill_count", io_count, 64'(i + 1));
      check("fill_head_pc", io_out_pc, 64'h8000_0000);
    end

    // Full with simultaneous offer and dequeue: dequeue only
    drive(1'b1, 64'h8000_0010, 32'h1000_0004, 1'b1, 1'b0);
    #1;
    check("full_in_ready", io_in_ready, 0);
    check("full_out_valid", io_out_valid, 1);
    check("full_head_pc", io_out_pc, 64'h8000_0000);
    check("full_head_inst", io_out_inst, 32'h1000_0000);
    tick();
    check("full_deq_count", io_count, 3);
    check("after_full_ready", io_in_ready, 1);
    check("after_full_head", io_out_pc, 64'h8000_0004);
    tick();
    check("enq_deq_count", io_count, 3);

    // Drain across pointer wrap, order preserved
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 2; i < 5; i++) begin
      #1;
      check("drain_valid", io_out_valid, 1);
      check("drain_pc", io_out_pc, 64'h8000_0000 + 64'(4 * i));
      check("drain_inst", io_out_inst, 32'h1000_0000 + 32'(i));
      tick();
    end
    check("drained_valid", io_out_valid, 0);
    check("drained_count", io_count, 0);
    check("drained_pc", io_out_pc, 0);

    // Streaming: ten back-to-back enqueues with decode always ready
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'h1000 + 64'(4 * k), 32'h2000 + 32'(k), 1'b1, 1'b0);
      #1;
`ifdef IFU_IQ_BYPASS_EN
      check("stream_valid", io_out_valid, 1);
      check("stream_pc", io_out_pc, 64'h1000 + 64'(4 * k));
      check("stream_count", io_count, 0);
`else
      if (k == 0) begin
        check("stream_first_valid", io_out_valid, 0);
        check("stream_first_count", io_count, 0);
      end else begin
        check("stream_pc", io_out_pc, 64'h1000 + 64'(4 * (k - 1)));
        check("stream_inst", io_out_inst, 32'h2000 + 32'(k - 1));
        check("stream_count", io_count, 1);
      end
`endif
      tick();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
`ifndef IFU_IQ_BYPASS_EN
    check("stream_last_pc", io_out_pc, 64'h1000 + 64'd36);
    tick();
`endif
    check("stream_end_valid", io_out_valid, 0);
    check("stream_end_count", io_count, 0);

    // Flush with three entries while a new one is offered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h2000 + 64'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h2100, 32'h3100, 1'b0, 1'b1);
    #1;
    check("flush_count_before", io_count, 3);
    check("flush_in_ready", io_in_ready, 0);
    check("flush_out_valid", io_out_valid, 0);
    check("flush_out_pc", io_out_pc, 0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("post_flush_count", io_count, 0);
    check("post_flush_valid", io_out_valid, 0);
    drive(1'b1, 64'h3000, 32'h0000_3000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("post_flush_head", io_out_pc, 64'h3000);
    check("post_flush_count1", io_count, 1);
    tick();
    check("post_flush_empty", io_count, 0);

    // Empty queue offer with decode ready: bypass or one-cycle latency
    drive(1'b1, 64'h4000, 32'h0000_0013, 1'b1, 1'b0);
    #1;
`ifdef IFU_IQ_BYPASS_EN
    check("bypass_valid", io_out_valid, 1);
    check("bypass_inst", io_out_inst, 32'h0000_0013);
    check("bypass_pc", io_out_pc, 64'h4000);
    tick();
    check("bypass_count", io_count, 0);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("bypass_after_valid", io_out_valid, 0);
`else
    check("nobypass_valid", io_out_valid, 0);
    check("nobypass_inst", io_out_inst, 0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("latency_valid", io_out_valid, 1);
    check("latency_inst", io_out_inst, 32'h0000_0013);
    check("latency_count", io_count, 1);
    tick();
    check("latency_after_valid", io_out_valid, 0);
`endif

    // Reset asserted mid-transfer
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h5000 + 64'(4 * i), 32'h5000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h5008, 32'h5002, 1'b1, 1'b0);
    #1;
    check("midrst_count_before", io_count, 2);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", io_in_ready, 0);
    check("midrst_out_valid", io_out_valid, 0);
    check("midrst_count", io_count, 0);
    check("midrst_out_pc", io_out_pc, 0);
    tick();
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rerst_count", io_count, 0);
    check("rerst_out_valid", io_out_valid, 0);
    check("rerst_in_ready", io_in_ready, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
